tdm_demux_16ch: RTL and testbench

- Receive-side counterpart of the team's 16:1 channel multiplexer, used when that mux is scanned as a time-division serializer.
- Accepts one serial bit per valid cycle, tagged by a frame-start marker on slot 0.
- Steers each bit to its channel position and presents the rebuilt 16-bit frame on a registered parallel output with a one-cycle valid pulse.
- Checks frame alignment and flags slips.

---
 rtl/tdm_demux_16ch.sv | 145 ++++++++++++++
 tb/tb_tdm_demux_16ch.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_16ch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tdm_demux_16ch
// Purpose  : Time-division demultiplexer. Collects one serial bit per valid
//            cycle, steers it to its slot position and publishes the rebuilt
//            16-bit frame on a registered parallel output with a one-cycle
//            valid pulse. Frame alignment is tracked by a frame-start marker
//            on slot 0. Early or missing markers are reported as sync errors.
// Ports    : clk         - single clock, rising edge
//            rst         - asynchronous active-high reset
//            in          - serial data bit for the current slot
//            in_valid    - in carries a bit this cycle
//            frame_start - marks the current bit as slot 0 (needs in_valid)
//            out         - last complete frame, out[k] = bit of slot k
//            out_valid   - one-cycle pulse when out updates
//            sel         - slot index for the next valid bit (0 while hunting)
//            locked      - high while aligned (RUN)
//            sync_err    - one-cycle pulse on an alignment violation
//            frame_cnt   - completed-frame counter, wraps
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux_16ch #(
    parameter int N   = 16,
    parameter int SW  = 4,
    parameter int FCW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in,
    input  logic           in_valid,
    input  logic           frame_start,
    output logic [N-1:0]   out,
    output logic           out_valid,
    output logic [SW-1:0]  sel,
    output logic           locked,
    output logic           sync_err,
    output logic [FCW-1:0] frame_cnt
);

    typedef enum logic [0:0] {
        ST_HUNT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [SW-1:0]  C_LAST_SLOT = SW'(N - 1);
    localparam logic [SW-1:0]  C_SLOT_ONE  = SW'(1);
    localparam logic [FCW-1:0] C_FC_ONE    = FCW'(1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [SW-1:0]  r_cnt;
    logic [SW-1:0]  w_cnt_nxt;
    // Slots 0..N-2 only; the last slot bit goes straight into the output.
    logic [N-2:0]   r_cap;
    logic [N-2:0]   w_cap_nxt;
    logic [N-1:0]   r_out;
    logic [N-1:0]   w_out_nxt;
    logic           r_out_valid;
    logic           w_out_valid_nxt;
    logic           r_sync_err;
    logic           w_sync_err_nxt;
    logic [FCW-1:0] r_frame_cnt;
    logic [FCW-1:0] w_frame_cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_HUNT;
            r_cnt       <= '0;
            r_cap       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_sync_err  <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cap       <= w_cap_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_sync_err  <= w_sync_err_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_cap_nxt       = r_cap;
        w_out_nxt       = r_out;
        w_out_valid_nxt = 1'b0;
        w_sync_err_nxt  = 1'b0;
        w_frame_cnt_nxt = r_frame_cnt;

        if (in_valid) begin
            case (r_state)
                ST_HUNT: begin
                    // Anything before the first marker is dropped silently.
                    if (frame_start) begin
                        w_cap_nxt[0] = in;
                        w_cnt_nxt    = C_SLOT_ONE;
                        w_state_nxt  = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (frame_start) begin
                        // A marker mid-frame means we slipped; restart the
                        // frame on this bit and drop the partial one.
                        if (r_cnt != '0) begin
                            w_sync_err_nxt = 1'b1;
                        end
                        w_cap_nxt[0] = in;
                        w_cnt_nxt    = C_SLOT_ONE;
                    end else if (r_cnt == '0) begin
                        // Slot 0 arrived without its marker: alignment lost.
                        w_sync_err_nxt = 1'b1;
                        w_state_nxt    = ST_HUNT;
                    end else if (r_cnt == C_LAST_SLOT) begin
                        w_out_nxt       = {in, r_cap};
                        w_out_valid_nxt = 1'b1;
                        w_frame_cnt_nxt = r_frame_cnt + C_FC_ONE;
                        w_cnt_nxt       = '0;
                    end else begin
                        w_cap_nxt[r_cnt] = in;
                        w_cnt_nxt        = r_cnt + C_SLOT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_HUNT;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // The counter is forced to 0 whenever RUN is left, so it doubles as sel.
    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign sel       = r_cnt;
    assign locked    = (r_state == ST_RUN);
    assign sync_err  = r_sync_err;
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux_16ch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tdm_demux_16ch
// Purpose  : Scoreboard bench for tdm_demux_16ch. The driver feeds a bit-level
//            reference model (a queue holding the partial frame) which pushes
//            expected frames and sync-error events with their expected cycle;
//            a separate monitor pops and compares whenever the DUT pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_demux_16ch;

    logic        clk;
    logic        rst;
    logic        din;
    logic        in_valid;
    logic        frame_start;
    logic [15:0] out;
    logic        out_valid;
    logic [3:0]  sel;
    logic        locked;
    logic        sync_err;
    logic [7:0]  frame_cnt;

    tdm_demux_16ch #(.N(16), .SW(4), .FCW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in          (din),
        .in_valid    (in_valid),
        .frame_start (frame_start),
        .out         (out),
        .out_valid   (out_valid),
        .sel         (sel),
        .locked      (locked),
        .sync_err    (sync_err),
        .frame_cnt   (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] val;
        logic [7:0]  fc;
        int          cyc;
    } exp_t;

    exp_t q_out[$];
    int   q_err[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: partial frame as a bit queue plus an aligned flag.
    bit   m_bits[$];
    bit   m_aligned = 0;
    int   m_fcnt    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bad(input string name, input int act, input int exp);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_bit(input bit b, input bit fs);
        exp_t e;
        if (fs) begin
            if (m_aligned && m_bits.size() != 0) q_err.push_back(cyc + 1);
            m_bits.delete();
            m_bits.push_back(b);
            m_aligned = 1;
        end else if (m_aligned) begin
            if (m_bits.size() == 0) begin
                // A frame just ended, so this bit needed a marker.
                q_err.push_back(cyc + 1);
                m_aligned = 0;
            end else begin
                m_bits.push_back(b);
                if (m_bits.size() == 16) begin
                    e.val = '0;
                    for (int i = 0; i < 16; i++) e.val[i] = m_bits[i];
                    m_fcnt = (m_fcnt + 1) % 256;
                    e.fc  = 8'(m_fcnt);
                    e.cyc = cyc + 1;
                    q_out.push_back(e);
                    m_bits.delete();
                end
            end
        end
    endtask

    task automatic drive(input bit v, input bit b, input bit fs);
        @(negedge clk);
        chk("sel", {28'd0, sel}, m_aligned ? m_bits.size() : 0);
        chk("locked", {31'd0, locked}, {31'd0, m_aligned});
        in_valid    = v;
        din         = b;
        frame_start = fs;
        if (v) model_bit(b, fs);
    endtask

    task automatic idle_random();
        drive(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
    endtask

    task automatic send_frame(input logic [15:0] val, input int gap_pct, input bit drop_marker);
        for (int k = 0; k < 16; k++) begin
            while (int'($urandom_range(99)) < gap_pct) idle_random();
            drive(1'b1, val[k], (k == 0) && !drop_marker);
        end
    endtask

    task automatic send_alt_gaps(input logic [15:0] val);
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, val[k], k == 0);
            if (k != 15) idle_random();
        end
    endtask

    task automatic send_partial(input logic [15:0] val, input int nbits);
        for (int k = 0; k < nbits; k++) drive(1'b1, val[k], k == 0);
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_aligned = 0;
        m_fcnt    = 0;
        q_out.delete();
        q_err.delete();
    endtask

    // Monitor: every DUT pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && sync_err) bad("overlap_valid_err", 1, 0);
            if (out_valid) begin
                if (q_out.size() == 0) begin
                    bad("unexpected_out_valid", cyc, -1);
                end else begin
                    exp_t e;
                    e = q_out.pop_front();
                    chk("out", {16'd0, out}, {16'd0, e.val});
                    chk("frame_cnt", {24'd0, frame_cnt}, {24'd0, e.fc});
                    chk("out_valid_cycle", cyc, e.cyc);
                end
            end
            if (sync_err) begin
                if (q_err.size() == 0) bad("unexpected_sync_err", cyc, -1);
                else chk("sync_err_cycle", cyc, q_err.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; din = 1'b0; in_valid = 1'b0; frame_start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out",       {16'd0, out},       32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sel",       {28'd0, sel},       32'd0);
        chk("rst_locked",    {31'd0, locked},    32'd0);
        chk("rst_sync_err",  {31'd0, sync_err},  32'd0);
        chk("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        rst = 1'b0;

        // Contiguous frame, then back-to-back frames.
        send_frame(16'hA5C3, 0, 0);
        send_frame(16'h0001, 0, 0);
        send_frame(16'h8000, 0, 0);
        // Gap on every other cycle.
        send_alt_gaps(16'hFFFF);
        // Early slip at slot 7, then a clean frame.
        send_partial(16'h6B2D, 7);
        send_frame(16'h1234, 0, 0);
        // Missing marker after a good frame, then relock.
        send_frame(16'hC0DE, 0, 0);
        send_frame(16'h7777, 0, 1);
        send_frame(16'h2468, 0, 0);

        // Asynchronous reset at slot 9.
        send_partial(16'h9F31, 9);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_sel", {28'd0, sel}, 32'd9);
        #2 rst = 1'b1;
        #1;
        chk("arst_out",       {16'd0, out},       32'd0);
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_sel",       {28'd0, sel},       32'd0);
        chk("arst_locked",    {31'd0, locked},    32'd0);
        chk("arst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        send_frame(16'h5A5A, 0, 0);

        // 255 more good frames so the counter wraps to 0.
        for (int f = 0; f < 255; f++) send_frame(16'($urandom), 10, 0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("frame_cnt_wrap", {24'd0, frame_cnt}, 32'd0);

        // Random frames with gaps, dropped markers and slips.
        for (int f = 0; f < 40; f++) begin
            int mode;
            mode = int'($urandom_range(9));
            if (mode == 0) send_frame(16'($urandom), 25, 1);
            else if (mode == 1) send_partial(16'($urandom), int'($urandom_range(1, 15)));
            send_frame(16'($urandom), 25, 0);
        end
        repeat (4) drive(1'b0, 1'b0, 1'b0);

        if (q_out.size() != 0) bad("missing_out_valid", 0, q_out.size());
        if (q_err.size() != 0) bad("missing_sync_err", 0, q_err.size());
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
